// File: rtl/scancode_fifo_if.sv
// ============================================================================
// Module      : scancode_fifo_if
// Description : Keyboard-byte input and CPU register bus bundle for scancode_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scancode_fifo_if;
    logic [7:0]  kb_data;
    logic        kb_valid;
    logic        reg_sel;
    logic [31:0] wdata;
    logic        wenable;
    logic [31:0] rdata;
    logic        int_pending;

    modport master (
        output kb_data, kb_valid, reg_sel, wdata, wenable,
        input  rdata, int_pending
    );

    modport slave (
        input  kb_data, kb_valid, reg_sel, wdata, wenable,
        output rdata, int_pending
    );
endinterface

`default_nettype wire

// File: rtl/scancode_fifo.sv
// ============================================================================
// Module      : scancode_fifo
// Description : PS/2 scancode FIFO with strobe synchronizer, CPU DATA/CTRL
//               registers and a level interrupt while bytes are queued.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scancode_fifo #(
    parameter int DEPTH = 16
) (
    input  logic            sys_clk_i,
    input  logic            rst_ni,
    scancode_fifo_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic          s1_q, s2_q, s3_q;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rp_q, rp_d;
    logic [PW-1:0] wp_q, wp_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          irq_q;

    logic push, ctrl_wr, pop_req, clr_req, flush_req;
    logic empty, full, do_pop, do_push, ovf_set;
    logic [7:0]  head;
    logic [31:0] data_word, status_word;
    logic        unused_wdata;

    assign push      = s2_q & ~s3_q;
    assign ctrl_wr   = bus.wenable & bus.reg_sel;
    assign pop_req   = ctrl_wr & bus.wdata[0];
    assign clr_req   = ctrl_wr & bus.wdata[1];
    assign flush_req = ctrl_wr & bus.wdata[2];
    assign unused_wdata = ^bus.wdata[31:3];

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop_req & ~empty & ~flush_req;
    assign do_push = push & ~flush_req & (~full | do_pop);
    assign ovf_set = push & ~flush_req & full & ~do_pop;

    always_comb begin
        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        ovf_d   = ovf_q & ~clr_req;
        if (flush_req) begin
            rp_d    = '0;
            wp_d    = '0;
            count_d = '0;
        end else begin
            if (do_pop)  rp_d = rp_q + PW'(1);
            if (do_push) wp_d = wp_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
            if (ovf_set) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            rp_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            s1_q    <= bus.kb_valid;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            irq_q   <= (count_d != '0);
        end
    end

    // Storage carries no reset; stale bytes are unreachable once pointers clear.
    always_ff @(posedge sys_clk_i) begin
        if (do_push) mem_q[wp_q] <= bus.kb_data;
    end

    assign head        = empty ? 8'h00 : mem_q[rp_q];
    assign data_word   = {~empty, {(23-CW){1'b0}}, count_q, head};
    assign status_word = {{(24-CW){1'b0}}, count_q, 5'b0, ovf_q, full, ~empty};

    assign bus.rdata       = bus.reg_sel ? status_word : data_word;
    assign bus.int_pending = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_scancode_fifo.sv
// ============================================================================
// Module      : tb_scancode_fifo
// Description : Directed scoreboard bench for scancode_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scancode_fifo;

    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [7:0]  exp_q[$];
    logic [31:0] v;

    scancode_fifo_if sif ();

    scancode_fifo #(.DEPTH(DEPTH)) dut (
        .sys_clk_i (clk),
        .rst_ni    (rst_n),
        .bus       (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic sel, output logic [31:0] val);
        sif.reg_sel = sel;
        #1;
        val = sif.rdata;
    endtask

    task automatic cpu_wr(input logic [31:0] d);
        @(negedge clk);
        sif.reg_sel = 1'b1;
        sif.wdata   = d;
        sif.wenable = 1'b1;
        @(negedge clk);
        sif.wenable = 1'b0;
        sif.wdata   = '0;
    endtask

    // Byte push; the optional CTRL write lands on the same edge as the push.
    task automatic kb_send(input logic [7:0] b, input logic do_wr, input logic [31:0] ctrl);
        @(negedge clk);
        sif.kb_data  = b;
        sif.kb_valid = 1'b1;
        @(negedge clk);
        sif.kb_valid = 1'b0;
        @(negedge clk);
        if (do_wr) begin
            sif.reg_sel = 1'b1;
            sif.wdata   = ctrl;
            sif.wenable = 1'b1;
        end
        @(negedge clk);
        sif.wenable = 1'b0;
        sif.wdata   = '0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        kb_send(b, 1'b0, 32'h0);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] d;
        logic [7:0]  e;
        e = exp_q.pop_front();
        rd(1'b0, d);
        check(tag, {d[31], 23'b0, d[7:0]}, {1'b1, 23'b0, e});
        cpu_wr(32'h1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        sif.kb_data  = '0;
        sif.kb_valid = 1'b0;
        sif.reg_sel  = 1'b0;
        sif.wdata    = '0;
        sif.wenable  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_int", {31'b0, sif.int_pending}, 32'h0);
        rd(1'b0, v); check("rst_data", v, 32'h0);
        rd(1'b1, v); check("rst_status", v, 32'h0);

        // Single byte
        push_byte(8'h1C);
        rd(1'b0, v); check("single_data", v, 32'h8000_011C);
        check("single_int", {31'b0, sif.int_pending}, 32'h1);
        void'(exp_q.pop_front());
        cpu_wr(32'h1);
        rd(1'b0, v); check("single_popped", v, 32'h0);
        check("single_int_clr", {31'b0, sif.int_pending}, 32'h0);

        // Fill and overflow
        for (int i = 0; i <= DEPTH; i++) push_byte(8'(i));
        rd(1'b1, v); check("full_status", v, 32'h0000_1007);
        for (int i = 0; i < DEPTH; i++) pop_check("fill_order");
        rd(1'b0, v); check("fill_drained", v, 32'h0);
        cpu_wr(32'h2);
        rd(1'b1, v); check("ovf_clear", v, 32'h0);

        // Wrap-around
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) push_byte(8'(8'h20 + r*10 + i));
            for (int i = 0; i < 10; i++) pop_check("wrap_order");
        end
        rd(1'b1, v); check("wrap_count", v, 32'h0);

        // Push + pop with count=5
        for (int i = 0; i < 5; i++) push_byte(8'(8'h60 + i));
        rd(1'b0, v); check("pp5_head", {24'b0, v[7:0]}, {24'b0, exp_q[0]});
        void'(exp_q.pop_front());
        exp_q.push_back(8'h6A);
        kb_send(8'h6A, 1'b1, 32'h1);
        rd(1'b1, v); check("pp5_status", v, 32'h0000_0501);
        for (int i = 0; i < 5; i++) pop_check("pp5_order");

        // Push + pop with count=0
        exp_q.push_back(8'h77);
        kb_send(8'h77, 1'b1, 32'h1);
        rd(1'b0, v); check("pp0_data", v, 32'h8000_0177);
        pop_check("pp0_pop");

        // Push + pop with count=16
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h80 + i));
        void'(exp_q.pop_front());
        exp_q.push_back(8'hA5);
        kb_send(8'hA5, 1'b1, 32'h1);
        rd(1'b1, v); check("pp16_status", v, 32'h0000_1003);
        for (int i = 0; i < DEPTH; i++) pop_check("pp16_order");
        rd(1'b1, v); check("pp16_empty", v, 32'h0);

        // Flush colliding with a push
        for (int i = 0; i < 7; i++) push_byte(8'(8'hC0 + i));
        rd(1'b1, v); check("flush_pre", v, 32'h0000_0701);
        kb_send(8'hEE, 1'b1, 32'h4);
        exp_q.delete();
        rd(1'b1, v); check("flush_status", v, 32'h0);
        check("flush_int", {31'b0, sif.int_pending}, 32'h0);
        rd(1'b0, v); check("flush_data", v, 32'h0);

        // Asynchronous reset between strobe and push
        push_byte(8'h33);
        check("arst_pre_int", {31'b0, sif.int_pending}, 32'h1);
        @(negedge clk);
        sif.kb_data  = 8'h44;
        sif.kb_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_int", {31'b0, sif.int_pending}, 32'h0);
        rd(1'b0, v); check("arst_data", v, 32'h0);
        rd(1'b1, v); check("arst_status", v, 32'h0);
        sif.kb_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rd(1'b1, v); check("arst_no_byte", v, 32'h0);
        check("arst_int_after", {31'b0, sif.int_pending}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
